// File: rtl/nn_pkg.sv
// Shared constants for the neuron-layer datapath: word width, layer sizes and
// the serializer state encoding.
package nn_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  localparam int L0 = 30;
  localparam int L1 = 30;
  localparam int L2 = 10;
  localparam int L3 = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_t;

endpackage

// File: rtl/layer_serializer_if.sv
// Connects a layer's parallel neuron outputs to the serial input of the next layer.
// The master side drives the layer outputs, and the slave side is the serializer.
interface layer_serializer_if #(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16
);

  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data;
  logic [NUM_NEURONS-1:0]            in_valid;
  logic [DATA_WIDTH-1:0]             out_data;
  logic                              out_valid;
  logic                              busy;
  logic                              err_overrun;
  logic                              err_partial;

  modport master (
    output in_data, in_valid,
    input  out_data, out_valid, busy, err_overrun, err_partial
  );

  modport slave (
    input  in_data, in_valid,
    output out_data, out_valid, busy, err_overrun, err_partial
  );

endinterface

// File: rtl/layer_serializer.sv
// Captures a full layer of activations and streams them one word per cycle,
// neuron 0 first. Overlapping or partial frames are flagged with sticky errors.
module layer_serializer
  import nn_pkg::*;
#(
  parameter  int NUM_NEURONS = L0,
  parameter  int DATA_WIDTH  = DATA_WIDTH_DEF,
  localparam int CNT_WIDTH   = $clog2(NUM_NEURONS) + 1
) (
  input logic              clk,
  input logic              rst,
  layer_serializer_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(NUM_NEURONS - 1);

  ser_state_t                   r_state;
  ser_state_t                   w_state_nxt;
  logic [CNT_WIDTH-1:0]         r_count;
  logic signed [DATA_WIDTH-1:0] r_buf [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]        r_out_data;
  logic                         r_out_valid;
  logic                         r_busy;
  logic                         r_err_overrun;
  logic                         r_err_partial;

  logic                         w_all;
  logic                         w_partial;
  logic                         w_last;
  logic                         w_load;
  logic                         w_overrun;
  logic signed [DATA_WIDTH-1:0] w_word;

  assign w_all     = &bus.in_valid;
  assign w_partial = (|bus.in_valid) && !w_all;
  assign w_last    = (r_count == LAST);

  // Explicit word select keeps the emitted order tied to the neuron index.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (r_count == CNT_WIDTH'(i)) w_word = r_buf[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_overrun   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_all) begin
          w_load      = 1'b1;
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (w_last) begin
          if (w_all) w_load = 1'b1;
          else       w_state_nxt = IDLE;
        end else if (w_all) begin
          w_overrun = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_count       <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_err_overrun <= 1'b0;
      r_err_partial <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) r_buf[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == STREAM);

      if (w_load) begin
        for (int i = 0; i < NUM_NEURONS; i++)
          r_buf[i] <= bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end

      // Reloading on the last word lets the next frame follow with no gap.
      if (w_load || (r_state == STREAM && w_last)) r_count <= '0;
      else if (r_state == STREAM)                  r_count <= r_count + CNT_WIDTH'(1);

      if (r_state == STREAM) begin
        r_out_data  <= w_word;
        r_out_valid <= 1'b1;
      end else begin
        r_out_data  <= '0;
        r_out_valid <= 1'b0;
      end

      r_err_overrun <= r_err_overrun | w_overrun;
      r_err_partial <= r_err_partial | w_partial;
    end
  end

  assign bus.out_data    = r_out_data;
  assign bus.out_valid   = r_out_valid;
  assign bus.busy        = r_busy;
  assign bus.err_overrun = r_err_overrun;
  assign bus.err_partial = r_err_partial;

endmodule

// File: tb/tb_layer_serializer.sv
// Directed bench for layer_serializer with a 4-neuron, 16-bit layer. It covers
// streaming order, back-to-back frames, overrun, partial valid, reset and sign.
module tb_layer_serializer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  layer_serializer_if #(.NUM_NEURONS(4), .DATA_WIDTH(16)) bus ();

  layer_serializer #(.NUM_NEURONS(4), .DATA_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [15:0] exp);
    chk({tag, "_vld"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_dat"}, {16'd0, bus.out_data}, {16'd0, exp});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_dat"}, {16'd0, bus.out_data}, 32'd0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.in_data  = '0;
    bus.in_valid = '0;
    step();
    step();

    chk_idle("rst");
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_ovr",  {31'd0, bus.err_overrun}, 32'd0);
    chk("rst_par",  {31'd0, bus.err_partial}, 32'd0);
    rst = 1'b0;
    step();

    // Basic frame
    bus.in_data  = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    bus.in_valid = 4'b1111;
    step();
    bus.in_valid = 4'b0000;
    chk_idle("b_lat");
    chk("b_busy0", {31'd0, bus.busy}, 32'd1);
    step(); chk_word("b_w0", 16'h0001);
    chk("b_busy1", {31'd0, bus.busy}, 32'd1);
    step(); chk_word("b_w1", 16'h0002);
    step(); chk_word("b_w2", 16'h0003);
    step(); chk_word("b_w3", 16'h0004);
    step(); chk_idle("b_end");
    chk("b_busy_end", {31'd0, bus.busy}, 32'd0);

    // Back-to-back: second frame sampled on the edge that presents 0x0004
    bus.in_data  = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    bus.in_valid = 4'b1111;
    step();
    bus.in_valid = 4'b0000;
    step(); chk_word("bb_w0", 16'h0001);
    step(); chk_word("bb_w1", 16'h0002);
    step(); chk_word("bb_w2", 16'h0003);
    bus.in_data  = {16'h00D0, 16'h00C0, 16'h00B0, 16'h00A0};
    bus.in_valid = 4'b1111;
    step(); chk_word("bb_w3", 16'h0004);
    bus.in_valid = 4'b0000;
    step(); chk_word("bb_w4", 16'h00A0);
    step(); chk_word("bb_w5", 16'h00B0);
    step(); chk_word("bb_w6", 16'h00C0);
    step(); chk_word("bb_w7", 16'h00D0);
    chk("bb_ovr", {31'd0, bus.err_overrun}, 32'd0);
    step(); chk_idle("bb_end");

    // Overrun: full frame applied while 0x0002 is presented
    bus.in_data  = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    bus.in_valid = 4'b1111;
    step();
    bus.in_valid = 4'b0000;
    step(); chk_word("ov_w0", 16'h0001);
    step(); chk_word("ov_w1", 16'h0002);
    bus.in_data  = {16'h0DDD, 16'h0CCC, 16'h0BBB, 16'h0AAA};
    bus.in_valid = 4'b1111;
    step(); chk_word("ov_w2", 16'h0003);
    bus.in_valid = 4'b0000;
    chk("ov_flag", {31'd0, bus.err_overrun}, 32'd1);
    step(); chk_word("ov_w3", 16'h0004);
    step(); chk_idle("ov_end");
    step(); step();
    chk_idle("ov_nodrop");
    chk("ov_sticky", {31'd0, bus.err_overrun}, 32'd1);

    // Partial valid
    bus.in_data  = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    bus.in_valid = 4'b0101;
    step();
    bus.in_valid = 4'b0000;
    chk("pv_flag", {31'd0, bus.err_partial}, 32'd1);
    step(); chk_idle("pv_none");
    chk("pv_busy", {31'd0, bus.busy}, 32'd0);
    bus.in_valid = 4'b1111;
    step();
    bus.in_valid = 4'b0000;
    step(); chk_word("pv_w0", 16'h4444);
    step(); chk_word("pv_w1", 16'h3333);
    step(); chk_word("pv_w2", 16'h2222);
    step(); chk_word("pv_w3", 16'h1111);
    step(); chk_idle("pv_end");
    chk("pv_sticky", {31'd0, bus.err_partial}, 32'd1);

    // Reset mid-stream while 0x0002 is presented
    bus.in_data  = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    bus.in_valid = 4'b1111;
    step();
    bus.in_valid = 4'b0000;
    step(); chk_word("rm_w0", 16'h0001);
    step(); chk_word("rm_w1", 16'h0002);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("rm_clr");
    chk("rm_busy", {31'd0, bus.busy}, 32'd0);
    chk("rm_ovr",  {31'd0, bus.err_overrun}, 32'd0);
    chk("rm_par",  {31'd0, bus.err_partial}, 32'd0);
    step(); chk_idle("rm_noresume");
    bus.in_data  = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    bus.in_valid = 4'b1111;
    step();
    bus.in_valid = 4'b0000;
    step(); chk_word("rm_n0", 16'h0011);
    step(); chk_word("rm_n1", 16'h0022);
    step(); chk_word("rm_n2", 16'h0033);
    step(); chk_word("rm_n3", 16'h0044);
    step(); chk_idle("rm_end");

    // Signed passthrough
    bus.in_data  = {16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000};
    bus.in_valid = 4'b1111;
    step();
    bus.in_valid = 4'b0000;
    step(); chk_word("sg_w0", 16'h0000);
    step(); chk_word("sg_w1", 16'h7FFF);
    step(); chk_word("sg_w2", 16'hFFFF);
    step(); chk_word("sg_w3", 16'h8000);
    step(); chk_idle("sg_end");
    chk("sg_ovr", {31'd0, bus.err_overrun}, 32'd0);
    chk("sg_par", {31'd0, bus.err_partial}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
